ndiag_seq: RTL and testbench

Sequencer that drives the off-diagonal sum-of-squares unit (`bu_ndiag`, result = a·a + accum after LAT cycles) over a vector held in local RAM. It fetches each element, issues it to the unit with the running accumulator, and waits for `data_available`. It then feeds the result back as the next accumulator and reports the final sum with a done pulse. It sits between the UKF control FSM (start/done) and one `bu_ndiag` instance in the Cholesky datapath.

---
 rtl/ndiag_seq_if.sv | 41 ++++
 rtl/ndiag_seq.sv | 163 ++++++++++++++++
 tb/tb_ndiag_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ndiag_seq_if.sv
// Bundle between ndiag_seq, the UKF control FSM, the local vector RAM and one bu_ndiag unit.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface ndiag_seq_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [31:0]       init_accum;
  logic              busy;
  logic              done;
  logic [31:0]       sum;
  logic              ovf;
  logic              unf;
  logic              error;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              bu_clk_en;
  logic [31:0]       bu_dataa_mul;
  logic [31:0]       bu_data_b_accum;
  logic              bu_data_in_flag;
  logic [31:0]       bu_result;
  logic              bu_data_available;
  logic              bu_overflow;
  logic              bu_underflow;

  modport slave (
    input  start, base_addr, len, init_accum, rd_data,
           bu_result, bu_data_available, bu_overflow, bu_underflow,
    output busy, done, sum, ovf, unf, error, rd_en, rd_addr,
           bu_clk_en, bu_dataa_mul, bu_data_b_accum, bu_data_in_flag
  );

  modport master (
    output start, base_addr, len, init_accum, rd_data,
           bu_result, bu_data_available, bu_overflow, bu_underflow,
    input  busy, done, sum, ovf, unf, error, rd_en, rd_addr,
           bu_clk_en, bu_dataa_mul, bu_data_b_accum, bu_data_in_flag
  );
endinterface

// File: rtl/ndiag_seq.sv
// Sequencer feeding a vector through one bu_ndiag unit, accumulating a*a into a running sum.
// Optional WAIT watchdog enabled by defining NDIAG_SEQ_TIMEOUT_EN.
module ndiag_seq #(
  parameter int ADDR_W  = 8,
  parameter int LAT     = 11,
  parameter int TIMEOUT = 32
) (
  input logic      clock,
  input logic      aclr,
  ndiag_seq_if.slave io
);
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic [31:0]       acc_q, acc_d, sum_q, sum_d, mul_q, mul_d, accop_q, accop_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, clken_q;
  logic [DW-1:0]     drain_q, drain_d;
  logic              rd_en, flag, done;

`ifdef NDIAG_SEQ_TIMEOUT_EN
  localparam int WLIM = LAT + TIMEOUT;
  localparam int WW   = $clog2(WLIM + 1);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    mul_d   = mul_q;
    accop_d = accop_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    drain_d = (drain_q != '0) ? drain_q - DW'(1) : drain_q;
    rd_en   = 1'b0;
    flag    = 1'b0;
    done    = 1'b0;
`ifdef NDIAG_SEQ_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // start is held off until stale unit outputs have drained after reset
        if (io.start && drain_q == '0) begin
          base_d  = io.base_addr;
          len_d   = io.len;
          acc_d   = io.init_accum;
          idx_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          sum_d   = '0;
`ifdef NDIAG_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (io.len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        flag    = 1'b1;
        mul_d   = io.rd_data;
        accop_d = acc_q;
`ifdef NDIAG_SEQ_TIMEOUT_EN
        wcnt_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io.bu_data_available) begin
          acc_d   = io.bu_result;
          ovf_d   = ovf_q | io.bu_overflow;
          unf_d   = unf_q | io.bu_underflow;
          idx_d   = idx_q + ADDR_W'(1);
          state_d = (idx_q + ADDR_W'(1) == len_q) ? S_DONE : S_READ;
        end
`ifdef NDIAG_SEQ_TIMEOUT_EN
        else if (wcnt_q == WW'(WLIM - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d  = wcnt_q + WW'(1);
        end
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // sum is loaded on DONE entry so it is already valid during the done pulse
    if (state_d == S_DONE) sum_d = acc_d;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      mul_q   <= '0;
      accop_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      clken_q <= 1'b0;
      drain_q <= DW'(LAT);
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      mul_q   <= mul_d;
      accop_q <= accop_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      clken_q <= 1'b1;
      drain_q <= drain_d;
    end
  end

`ifdef NDIAG_SEQ_TIMEOUT_EN
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end
  assign io.error = err_q;
`else
  assign io.error = 1'b0;
`endif

  assign io.busy            = (state_q != S_IDLE);
  assign io.done            = done;
  assign io.sum             = sum_q;
  assign io.ovf             = ovf_q;
  assign io.unf             = unf_q;
  assign io.rd_en           = rd_en;
  assign io.rd_addr         = base_q + idx_q;
  assign io.bu_clk_en       = clken_q;
  assign io.bu_data_in_flag = flag;
  // operands follow the RAM word during ISSUE and hold it afterwards
  assign io.bu_dataa_mul    = flag ? io.rd_data : mul_q;
  assign io.bu_data_b_accum = flag ? acc_q : accop_q;
endmodule

// File: tb/tb_ndiag_seq.sv
// Directed bench for ndiag_seq: RAM model, table-driven bu_ndiag model, hand-computed expectations.
module tb_ndiag_seq;
  localparam int LAT = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ndiag_seq_if #(.ADDR_W(8)) bus ();
  ndiag_seq #(.ADDR_W(8), .LAT(LAT), .TIMEOUT(32)) u_dut (.clock(clk), .aclr(rst), .io(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0BAD_0000 | i;
    ram[8'h10] = 32'h3F80_0000; ram[8'h11] = 32'h4000_0000; ram[8'h12] = 32'h4040_0000;
    ram[8'hFE] = 32'h3F80_0000; ram[8'hFF] = 32'h4000_0000; ram[8'h00] = 32'h4040_0000;
    ram[8'h20] = 32'h7F00_0000; ram[8'h21] = 32'h0080_0000;
  end
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  // a*a + b for the operand pairs the scenarios produce
  function automatic logic [31:0] sq_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h0000_0000}: return 32'h3F80_0000;
      {32'h4000_0000, 32'h3F80_0000}: return 32'h40A0_0000;
      {32'h4040_0000, 32'h40A0_0000}: return 32'h4160_0000;
      {32'h7F00_0000, 32'h0000_0000}: return 32'h7F80_0000;
      {32'h0080_0000, 32'h0000_0000}: return 32'h0000_0000;
      default:                        return 32'hBAD0_BAD0;
    endcase
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [31:0]    pd [LAT];
  int             issue_cnt = 0;
  int             drop_at = -1;
  logic           inject = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], bus.bu_data_in_flag && (issue_cnt != drop_at)};
    pd[0] <= sq_add(bus.bu_dataa_mul, bus.bu_data_b_accum);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    if (bus.bu_data_in_flag) issue_cnt <= issue_cnt + 1;
  end
  assign bus.bu_data_available = pv[LAT-1] | inject;
  assign bus.bu_result         = inject ? 32'hDEAD_BEEF : pd[LAT-1];
  assign bus.bu_overflow       = bus.bu_data_available & (bus.bu_result == 32'h7F80_0000);
  assign bus.bu_underflow      = pv[LAT-1] & (pd[LAT-1] == 32'h0);

  logic [7:0] addrs [$];
  int done_at, busy_n;

  // start sampled at the edge ending cycle t0; k counts cycles after t0
  task automatic run_job(input logic [7:0] b, input logic [7:0] l, input logic [31:0] ia,
                         input int maxc, input int poke);
    addrs.delete();
    done_at = -1;
    busy_n  = 0;
    bus.base_addr  = b;
    bus.len        = l;
    bus.init_accum = ia;
    bus.start      = 1'b1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      bus.start = (k == poke);
      if (bus.busy) busy_n++;
      if (bus.rd_en) addrs.push_back(bus.rd_addr);
      if (bus.done) begin
        done_at = k;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.init_accum = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
    chk("rst_done",  {31'b0, bus.done}, 32'd0);
    chk("rst_sum",   bus.sum, 32'h0);
    chk("rst_clken", {31'b0, bus.bu_clk_en}, 32'd0);
    chk("rst_rden",  {31'b0, bus.rd_en}, 32'd0);
    chk("rst_op",    bus.bu_dataa_mul | bus.bu_data_b_accum, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("clken", {31'b0, bus.bu_clk_en}, 32'd1);
    bus.start = 1'b1; bus.len = 8'd3;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    chk("drain_ign", {31'b0, bus.busy}, 32'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);

    run_job(8'h10, 8'd3, 32'h0, 100, -1);
    chk("s1_done_at", done_at, 32'd40);
    chk("s1_sum",     bus.sum, 32'h4160_0000);
    chk("s1_busy_n",  busy_n, 32'd40);
    chk("s1_err",     {31'b0, bus.error}, 32'd0);
    chk("s1_ovf",     {31'b0, bus.ovf}, 32'd0);
    chk("s1_rd_n",    addrs.size(), 32'd3);
    @(negedge clk);
    chk("s1_idle",    {31'b0, bus.busy}, 32'd0);

    run_job(8'h10, 8'd0, 32'h40A0_0000, 20, -1);
    chk("s2_done_at", done_at, 32'd1);
    chk("s2_sum",     bus.sum, 32'h40A0_0000);
    chk("s2_rd_n",    addrs.size(), 32'd0);
    @(negedge clk);

    run_job(8'hFE, 8'd3, 32'h0, 100, -1);
    chk("s3_n",   addrs.size(), 32'd3);
    if (addrs.size() == 3) begin
      chk("s3_a0", {24'b0, addrs[0]}, 32'hFE);
      chk("s3_a1", {24'b0, addrs[1]}, 32'hFF);
      chk("s3_a2", {24'b0, addrs[2]}, 32'h00);
    end
    chk("s3_sum", bus.sum, 32'h4160_0000);
    @(negedge clk);

    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("s4_inj_busy", {31'b0, bus.busy}, 32'd0);
    chk("s4_inj_sum",  bus.sum, 32'h4160_0000);
    run_job(8'h10, 8'd3, 32'h0, 100, 20);
    chk("s4_done_at", done_at, 32'd40);
    chk("s4_sum",     bus.sum, 32'h4160_0000);
    @(negedge clk);
    chk("s4_idle",    {31'b0, bus.busy}, 32'd0);

    run_job(8'h20, 8'd1, 32'h0, 40, -1);
    chk("s5_done_at", done_at, 32'd14);
    chk("s5_sum",     bus.sum, 32'h7F80_0000);
    chk("s5_ovf",     {31'b0, bus.ovf}, 32'd1);
    chk("s5_unf",     {31'b0, bus.unf}, 32'd0);
    @(negedge clk);
    run_job(8'h21, 8'd1, 32'h0, 40, -1);
    chk("s6_ovf",     {31'b0, bus.ovf}, 32'd0);
    chk("s6_unf",     {31'b0, bus.unf}, 32'd1);
    @(negedge clk);

    run_job(8'h10, 8'd3, 32'h0, 20, -1);
    chk("s7_busy_pre", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("s7_busy", {31'b0, bus.busy}, 32'd0);
    chk("s7_sum",  bus.sum, 32'h0);
    chk("s7_flag", {31'b0, bus.bu_data_in_flag} | {31'b0, bus.rd_en} | {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd3;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    chk("s7_drain_ign", {31'b0, bus.busy}, 32'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    run_job(8'h10, 8'd3, 32'h0, 100, -1);
    chk("s7_done_at", done_at, 32'd40);
    chk("s7_sum2",    bus.sum, 32'h4160_0000);
    @(negedge clk);

    drop_at = issue_cnt + 1;
    run_job(8'h10, 8'd3, 32'h0, 150, -1);
`ifdef NDIAG_SEQ_TIMEOUT_EN
    chk("s8_done_at", done_at, 32'd59);
    chk("s8_err",     {31'b0, bus.error}, 32'd1);
    chk("s8_sum",     bus.sum, 32'h3F80_0000);
`else
    chk("s8_nodone",  done_at, 32'hFFFF_FFFF);
    chk("s8_busy",    {31'b0, bus.busy}, 32'd1);
    chk("s8_err",     {31'b0, bus.error}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
